// File: rtl/ext_bus_scheduler_pkg.sv
// rtl/ext_bus_scheduler_pkg.sv - shared types and constants for the Beeb external bus scheduler
// Grant encoding, idle bus values and the slowdown latch address.
package ext_bus_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CPU  = 2'd1,
      ST_DBG  = 2'd2
   } grant_t;

   localparam logic [15:0] IDLE_ADDR  = 16'hFFFF;
   localparam logic [7:0]  IDLE_DATA  = 8'hFF;
   localparam logic [15:0] LATCH_ADDR = 16'hFE40;

   // A zero low field selects the long stretch; anything else uses the short one.
   function automatic logic [3:0] slow_load_val(input logic [7:0] dout,
                                                input logic [3:0] long_v,
                                                input logic [3:0] short_v);
      return (dout[2:0] == 3'd0) ? long_v : short_v;
   endfunction

endpackage

// File: rtl/ext_bus_scheduler_phi_edge_sync.sv
// rtl/ext_bus_scheduler_phi_edge_sync.sv - Phi0 synchroniser and cycle edge detector
// Four-stage chain on the raw Phi0; cycle_end marks its falling edge, cycle_start follows one clock later.
module phi_edge_sync (
   input  logic clock,
   input  logic Res_n,
   input  logic PhiIn,
   output logic ph_c,
   output logic cycle_end,
   output logic cycle_start
);

   logic r_ph_a;
   logic r_ph_b;
   logic r_ph_c;
   logic r_ph_d;
   logic r_cycle_start;
   logic w_cycle_end;

   assign w_cycle_end = r_ph_d & ~r_ph_c;

   always_ff @(posedge clock or negedge Res_n) begin
      if (!Res_n) begin
         r_ph_a        <= 1'b0;
         r_ph_b        <= 1'b0;
         r_ph_c        <= 1'b0;
         r_ph_d        <= 1'b0;
         r_cycle_start <= 1'b0;
      end else begin
         r_ph_a        <= PhiIn;
         r_ph_b        <= r_ph_a;
         r_ph_c        <= r_ph_b;
         r_ph_d        <= r_ph_c;
         r_cycle_start <= w_cycle_end;
      end
   end

   assign ph_c        = r_ph_c;
   assign cycle_end   = w_cycle_end;
   assign cycle_start = r_cycle_start;

endmodule

// File: rtl/ext_bus_scheduler.sv
// rtl/ext_bus_scheduler.sv - arbitrates CPU and debug-port cycles onto the Beeb Phi0 bus
// One bus cycle per Phi0 period; round-robin between two requesters plus the FE40 slowdown counter.
module ext_bus_scheduler
   import ext_bus_scheduler_pkg::*;
#(
   parameter int SLOW_LONG  = 15,
   parameter int SLOW_SHORT = 1
) (
   input  logic        clock,
   input  logic        Res_n,
   input  logic        PhiIn,
   input  logic        cpu_req,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_we,
   input  logic [7:0]  cpu_dout,
   output logic        cpu_ack,
   input  logic        dbg_req,
   input  logic [15:0] dbg_addr,
   input  logic        dbg_we,
   input  logic [7:0]  dbg_dout,
   output logic        dbg_ack,
   input  logic [7:0]  bus_din,
   output logic [7:0]  rd_data,
   output logic [15:0] bus_addr,
   output logic        bus_we,
   output logic [7:0]  bus_dout,
   output logic        bus_drive,
   output logic        slow
);

   localparam logic [3:0] LONG_V  = SLOW_LONG[3:0];
   localparam logic [3:0] SHORT_V = SLOW_SHORT[3:0];

   logic        w_ph_c;
   logic        w_cycle_end;
   logic        w_cycle_start;
   logic        w_cpu_wins;
   logic        w_dbg_wins;
   logic        w_active;
   logic        w_latch_wr;

   grant_t      r_state;
   logic        r_last_dbg;
   logic [15:0] r_bus_addr;
   logic        r_bus_we;
   logic [7:0]  r_bus_dout;
   logic [7:0]  r_rd_data;
   logic        r_cpu_ack;
   logic        r_dbg_ack;
   logic [3:0]  r_slow_cnt;

   phi_edge_sync u_phi (
      .clock       (clock),
      .Res_n       (Res_n),
      .PhiIn       (PhiIn),
      .ph_c        (w_ph_c),
      .cycle_end   (w_cycle_end),
      .cycle_start (w_cycle_start)
   );

   // r_last_dbg resets high so the CPU wins the first contended cycle.
   assign w_cpu_wins = cpu_req & (~dbg_req | r_last_dbg);
   assign w_dbg_wins = dbg_req & ~w_cpu_wins;
   assign w_active   = (r_state != ST_IDLE);
   assign w_latch_wr = w_cycle_end & w_active & r_bus_we & (r_bus_addr == LATCH_ADDR);

   always_ff @(posedge clock or negedge Res_n) begin
      if (!Res_n) begin
         r_state    <= ST_IDLE;
         r_last_dbg <= 1'b1;
         r_bus_addr <= IDLE_ADDR;
         r_bus_we   <= 1'b0;
         r_bus_dout <= IDLE_DATA;
         r_rd_data  <= 8'h00;
         r_cpu_ack  <= 1'b0;
         r_dbg_ack  <= 1'b0;
      end else begin
         r_cpu_ack <= 1'b0;
         r_dbg_ack <= 1'b0;
         if (w_cycle_start) begin
            if (w_cpu_wins) begin
               r_state    <= ST_CPU;
               r_last_dbg <= 1'b0;
               r_bus_addr <= cpu_addr;
               r_bus_we   <= cpu_we;
               r_bus_dout <= cpu_dout;
            end else if (w_dbg_wins) begin
               r_state    <= ST_DBG;
               r_last_dbg <= 1'b1;
               r_bus_addr <= dbg_addr;
               r_bus_we   <= dbg_we;
               r_bus_dout <= dbg_dout;
            end else begin
               r_state    <= ST_IDLE;
               r_bus_addr <= IDLE_ADDR;
               r_bus_we   <= 1'b0;
               r_bus_dout <= IDLE_DATA;
            end
         end
         // cycle_start never coincides with cycle_end, so state is stable here.
         if (w_cycle_end && w_active) begin
            r_rd_data <= bus_din;
            if (r_state == ST_CPU) begin
               r_cpu_ack <= 1'b1;
            end else begin
               r_dbg_ack <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge Res_n) begin
      if (!Res_n) begin
         r_slow_cnt <= 4'd0;
      end else if (w_latch_wr) begin
         r_slow_cnt <= slow_load_val(r_bus_dout, LONG_V, SHORT_V);
      end else if (w_cycle_end && (r_slow_cnt != 4'd0)) begin
         r_slow_cnt <= r_slow_cnt - 4'd1;
      end
   end

   assign cpu_ack   = r_cpu_ack;
   assign dbg_ack   = r_dbg_ack;
   assign rd_data   = r_rd_data;
   assign bus_addr  = r_bus_addr;
   assign bus_we    = r_bus_we;
   assign bus_dout  = r_bus_dout;
   assign bus_drive = w_ph_c & r_bus_we & w_active;
   assign slow      = (r_slow_cnt != 4'd0);

endmodule

// File: tb/tb_ext_bus_scheduler.sv
// tb/tb_ext_bus_scheduler.sv - directed bench for ext_bus_scheduler
// 62.5 MHz clock with Phi0 at exactly 32 clocks per period, offset from the clock edges.
`timescale 1ns/1ps
module tb_ext_bus_scheduler;

   logic        clock;
   logic        Res_n;
   logic        PhiIn;
   logic        cpu_req;
   logic [15:0] cpu_addr;
   logic        cpu_we;
   logic [7:0]  cpu_dout;
   logic        cpu_ack;
   logic        dbg_req;
   logic [15:0] dbg_addr;
   logic        dbg_we;
   logic [7:0]  dbg_dout;
   logic        dbg_ack;
   logic [7:0]  bus_din;
   logic [7:0]  rd_data;
   logic [15:0] bus_addr;
   logic        bus_we;
   logic [7:0]  bus_dout;
   logic        bus_drive;
   logic        slow;

   int n_total = 0;
   int n_bad   = 0;
   int n_cpu_ack = 0;
   int n_dbg_ack = 0;
   int n_both    = 0;

   logic        g_acked;
   logic        g_saw_drive;
   int          g_addr_bad;
   logic [7:0]  g_rd;
   logic [15:0] g_addr;
   logic        g_we;
   logic [7:0]  g_dout;
   logic        g_slow;

   ext_bus_scheduler dut (
      .clock     (clock),
      .Res_n     (Res_n),
      .PhiIn     (PhiIn),
      .cpu_req   (cpu_req),
      .cpu_addr  (cpu_addr),
      .cpu_we    (cpu_we),
      .cpu_dout  (cpu_dout),
      .cpu_ack   (cpu_ack),
      .dbg_req   (dbg_req),
      .dbg_addr  (dbg_addr),
      .dbg_we    (dbg_we),
      .dbg_dout  (dbg_dout),
      .dbg_ack   (dbg_ack),
      .bus_din   (bus_din),
      .rd_data   (rd_data),
      .bus_addr  (bus_addr),
      .bus_we    (bus_we),
      .bus_dout  (bus_dout),
      .bus_drive (bus_drive),
      .slow      (slow)
   );

   initial begin
      clock = 1'b0;
      forever #8 clock = ~clock;
   end

   initial begin
      PhiIn = 1'b0;
      #3;
      forever #256 PhiIn = ~PhiIn;
   end

   always @(negedge clock) begin
      if (cpu_ack) n_cpu_ack++;
      if (dbg_ack) n_dbg_ack++;
      if (cpu_ack && dbg_ack) n_both++;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one request and return at the negedge where its ack is seen, req already dropped.
   task automatic run_req(input bit is_dbg, input logic [15:0] a, input logic we, input logic [7:0] d);
      bit seen;
      seen = 1'b0;
      g_acked = 1'b0;
      g_saw_drive = 1'b0;
      g_addr_bad = 0;
      @(negedge clock);
      if (is_dbg) begin
         dbg_req = 1'b1; dbg_addr = a; dbg_we = we; dbg_dout = d;
      end else begin
         cpu_req = 1'b1; cpu_addr = a; cpu_we = we; cpu_dout = d;
      end
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (bus_addr == a) seen = 1'b1;
         else if (seen) g_addr_bad++;
         if (bus_drive) g_saw_drive = 1'b1;
         if (is_dbg ? dbg_ack : cpu_ack) begin
            g_acked = 1'b1;
            g_rd    = rd_data;
            g_addr  = bus_addr;
            g_we    = bus_we;
            g_dout  = bus_dout;
            g_slow  = slow;
            break;
         end
      end
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      chk("req_acked", {31'd0, g_acked}, 32'd1);
   endtask

   task automatic measure_slow(output int hi, output logic [3:0] cnt_at_160);
      hi = 0;
      cnt_at_160 = 4'hx;
      for (int i = 0; i < 1000; i++) begin
         if (i == 160) cnt_at_160 = dut.r_slow_cnt;
         if (slow) hi++;
         else break;
         @(negedge clock);
      end
   endtask

   task automatic do_reset;
      @(negedge clock);
      Res_n = 1'b0;
      repeat (4) @(negedge clock);
      Res_n = 1'b1;
   endtask

   initial begin
      int k;
      int prev_i;
      int seq [4];
      int viol;
      int hi;
      int acks_before;
      logic [3:0] cnt160;
      logic saw;

      Res_n = 1'b0;
      cpu_req = 1'b0; cpu_addr = 16'h0000; cpu_we = 1'b0; cpu_dout = 8'h00;
      dbg_req = 1'b0; dbg_addr = 16'h0000; dbg_we = 1'b0; dbg_dout = 8'h00;
      bus_din = 8'h00;
      repeat (3) @(negedge clock);
      chk("rst_addr",  {16'd0, bus_addr}, 32'hFFFF);
      chk("rst_we",    {31'd0, bus_we}, 32'd0);
      chk("rst_dout",  {24'd0, bus_dout}, 32'hFF);
      chk("rst_drive", {31'd0, bus_drive}, 32'd0);
      chk("rst_rd",    {24'd0, rd_data}, 32'h00);
      chk("rst_acks",  {30'd0, cpu_ack, dbg_ack}, 32'd0);
      chk("rst_slow",  {31'd0, slow}, 32'd0);
      Res_n = 1'b1;

      // Ten idle Phi0 periods.
      viol = 0;
      for (int i = 0; i < 320; i++) begin
         @(negedge clock);
         if (bus_drive || bus_addr != 16'hFFFF || bus_we || bus_dout != 8'hFF) viol++;
      end
      chk("idle_viol", viol, 0);

      // CPU read of FE4D.
      bus_din = 8'h5A;
      acks_before = n_cpu_ack;
      run_req(1'b0, 16'hFE4D, 1'b0, 8'h00);
      chk("rd_data",     {24'd0, g_rd}, 32'h5A);
      chk("rd_addr",     {16'd0, g_addr}, 32'hFE4D);
      chk("rd_addr_hold", g_addr_bad, 0);
      chk("rd_no_drive", {31'd0, g_saw_drive}, 32'd0);
      repeat (64) @(negedge clock);
      chk("rd_one_ack", n_cpu_ack - acks_before, 1);
      chk("rd_idle_addr", {16'd0, bus_addr}, 32'hFFFF);

      // Contended requests alternate starting with the CPU, one Phi0 period apart.
      do_reset();
      bus_din = 8'hA5;
      k = 0;
      prev_i = 0;
      for (int j = 0; j < 4; j++) seq[j] = -1;
      @(negedge clock);
      cpu_req = 1'b1; cpu_addr = 16'h1234; cpu_we = 1'b0;
      dbg_req = 1'b1; dbg_addr = 16'hABCD; dbg_we = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clock);
         if (cpu_ack || dbg_ack) begin
            seq[k] = dbg_ack ? 1 : 0;
            chk("rr_addr", {16'd0, bus_addr}, dbg_ack ? 32'hABCD : 32'h1234);
            if (k > 0) chk("rr_gap", i - prev_i, 32);
            prev_i = i;
            k++;
            if (k == 4) begin
               cpu_req = 1'b0;
               dbg_req = 1'b0;
               break;
            end
         end
      end
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      chk("rr_count", k, 4);
      chk("rr_0", seq[0], 0);
      chk("rr_1", seq[1], 1);
      chk("rr_2", seq[2], 0);
      chk("rr_3", seq[3], 1);

      // FE40 write with zero low bits: long slowdown, 15 Phi0 periods.
      run_req(1'b0, 16'hFE40, 1'b1, 8'h00);
      chk("wl_we",    {31'd0, g_we}, 32'd1);
      chk("wl_dout",  {24'd0, g_dout}, 32'h00);
      chk("wl_drive", {31'd0, g_saw_drive}, 32'd1);
      chk("wl_slow",  {31'd0, g_slow}, 32'd1);
      measure_slow(hi, cnt160);
      chk("wl_cnt_after5", {28'd0, cnt160}, 32'd10);
      chk("wl_slow_len", hi, 480);

      // FE40 write with non-zero low bits: one Phi0 period.
      run_req(1'b0, 16'hFE40, 1'b1, 8'h0B);
      chk("ws_slow", {31'd0, g_slow}, 32'd1);
      measure_slow(hi, cnt160);
      chk("ws_slow_len", hi, 32);

      // Writes elsewhere leave the counter alone.
      run_req(1'b1, 16'hFE41, 1'b1, 8'h00);
      chk("wo_slow", {31'd0, g_slow}, 32'd0);

      // Reset in the middle of a granted DBG write.
      @(negedge clock);
      dbg_req = 1'b1; dbg_addr = 16'h1111; dbg_we = 1'b1; dbg_dout = 8'h77;
      saw = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (bus_drive) begin
            saw = 1'b1;
            break;
         end
      end
      chk("rs_granted", {31'd0, saw}, 32'd1);
      acks_before = n_dbg_ack;
      Res_n = 1'b0;
      #1;
      chk("rs_addr",  {16'd0, bus_addr}, 32'hFFFF);
      chk("rs_drive", {31'd0, bus_drive}, 32'd0);
      chk("rs_we",    {31'd0, bus_we}, 32'd0);
      repeat (40) @(negedge clock);
      chk("rs_no_ack", n_dbg_ack - acks_before, 0);
      Res_n = 1'b1;
      bus_din = 8'h3C;
      saw = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (dbg_ack) begin
            saw = 1'b1;
            break;
         end
      end
      dbg_req = 1'b0;
      chk("rs_reack", {31'd0, saw}, 32'd1);
      repeat (64) @(negedge clock);
      chk("rs_ack_count", n_dbg_ack - acks_before, 1);

      chk("both_ack", n_both, 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
